// File: rtl/trigger_event_sequencer.sv
// Trigger qualification, edge acceptance and per-event acquisition sequencing.
// Emits one descriptor word per accepted trigger and one per aborted event.
module trigger_event_sequencer #(
  parameter int G_CHANNELS    = 8,
  parameter int G_FIFO_DEPTH  = 16384,
  parameter int G_CNT_WIDTH   = 15,
  parameter int G_SPE_WIDTH   = 32,
  parameter int G_EVNUM_WIDTH = 14,
  parameter int G_DATA_WIDTH  = 18,
  localparam int MAJ_W = $clog2(G_CHANNELS + 1)
) (
  input  logic                     Clock,
  input  logic                     Reset_N,
  input  logic                     Ctrl_Enable,
  input  logic                     Ctrl_Abort,
  input  logic [G_EVNUM_WIDTH-1:0] Ctrl_EventNum,
  input  logic [G_SPE_WIDTH-1:0]   Ctrl_SamplesPerEvent,
  input  logic [2:0]               Ctrl_TriggerSelect,
  input  logic [MAJ_W-1:0]         Ctrl_Majority,
  input  logic [G_CHANNELS-1:0]    TRG_ChannelMask,
  input  logic [G_CHANNELS-1:0]    TRG_Detect_Vector,
  input  logic                     EXT_TriggerInput,
  input  logic                     SW_Trigger,
  input  logic [G_CNT_WIDTH-1:0]   Fifo_WrCount,
  input  logic                     Fifo_AFull,
  output logic                     Acq_Run,
  output logic                     Event_We,
  output logic [G_DATA_WIDTH-1:0]  Event_Data,
  output logic                     Trigger_Out,
  output logic                     Busy,
  output logic                     NotFree,
  output logic                     Done,
  output logic [G_EVNUM_WIDTH-1:0] Event_Count
);

  localparam int NF_W = G_CNT_WIDTH + G_SPE_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ARMED, ACQUIRE, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [G_SPE_WIDTH-1:0]   rem_reg, rem_next;
  logic [G_EVNUM_WIDTH-1:0] count_reg, count_next, count_inc;
  logic [G_DATA_WIDTH-1:0]  data_reg, data_next, desc_ok, desc_abort;
  logic                     trig_out_reg, trig_out_next;
  logic                     we_reg, we_next;
  logic                     block_reg, block_next;
  logic                     trig_q_reg, trig_d_reg;
  logic                     notfree_reg;

  logic [G_CHANNELS-1:0]    masked;
  logic [MAJ_W-1:0]         pop, maj_eff;
  logic                     qualified, trig_edge;
  logic [G_SPE_WIDTH-1:0]   spe_eff;
  logic [NF_W-1:0]          need_words;
  logic [15:0]              cnt16;

  assign masked  = TRG_Detect_Vector & TRG_ChannelMask;
  assign maj_eff = (Ctrl_Majority == '0) ? MAJ_W'(1) : Ctrl_Majority;
  assign spe_eff = (Ctrl_SamplesPerEvent == '0) ? G_SPE_WIDTH'(1) : Ctrl_SamplesPerEvent;

  always_comb begin
    pop = '0;
    for (int i = 0; i < G_CHANNELS; i++) pop = pop + MAJ_W'(masked[i]);
  end

  always_comb begin
    qualified = 1'b0;
    case (Ctrl_TriggerSelect)
      3'd0: qualified = EXT_TriggerInput;
      3'd1: qualified = |masked;
      3'd2: qualified = (TRG_ChannelMask != '0) && (masked == TRG_ChannelMask);
      3'd3: qualified = (pop >= maj_eff);
      3'd4: qualified = SW_Trigger;
      default: qualified = 1'b0;
    endcase
  end

  assign trig_edge = trig_q_reg & ~trig_d_reg;

  // Wide enough that WrCount + SPE can never overflow, so no wrap is possible.
  assign need_words = NF_W'(Fifo_WrCount) + NF_W'(spe_eff);

  // Descriptor count field is always 16 bits: zero-extend or truncate the counter.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cnt16
      if (gi < G_EVNUM_WIDTH) begin : g_bit
        assign cnt16[gi] = count_reg[gi];
      end else begin : g_zero
        assign cnt16[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    desc_ok = '0;
    desc_ok[15:0] = cnt16;
    desc_ok[G_DATA_WIDTH-1 -: 2] = 2'b01;
    desc_abort = '0;
    desc_abort[15:0] = cnt16;
    desc_abort[G_DATA_WIDTH-1 -: 2] = 2'b10;
  end

  assign count_inc = count_reg + G_EVNUM_WIDTH'(1);

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    count_next    = count_reg;
    data_next     = data_reg;
    trig_out_next = 1'b0;
    we_next       = 1'b0;
    block_next    = block_reg & Ctrl_Enable;
    case (state_reg)
      IDLE: begin
        if (Ctrl_Enable && !Ctrl_Abort && !block_reg) begin
          state_next = ARMED;
          count_next = '0;
        end
      end
      ARMED: begin
        if (Ctrl_Abort || !Ctrl_Enable) begin
          state_next = IDLE;
        end else if (trig_edge && !notfree_reg && !Fifo_AFull) begin
          state_next    = ACQUIRE;
          rem_next      = spe_eff - G_SPE_WIDTH'(1);
          trig_out_next = 1'b1;
          we_next       = 1'b1;
          data_next     = desc_ok;
        end
      end
      ACQUIRE: begin
        if (Ctrl_Abort) begin
          state_next = IDLE;
          we_next    = 1'b1;
          data_next  = desc_abort;
        end else if (rem_reg == '0) begin
          count_next = count_inc;
          if ((Ctrl_EventNum != '0) && (count_inc == Ctrl_EventNum)) state_next = DONE;
          else state_next = ARMED;
        end else begin
          rem_next = rem_reg - G_SPE_WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        // Re-arming waits until Enable has been seen low at least once.
        block_next = Ctrl_Enable;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      trig_out_reg <= 1'b0;
      we_reg       <= 1'b0;
      block_reg    <= 1'b0;
      trig_q_reg   <= 1'b0;
      trig_d_reg   <= 1'b0;
      notfree_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      count_reg    <= count_next;
      data_reg     <= data_next;
      trig_out_reg <= trig_out_next;
      we_reg       <= we_next;
      block_reg    <= block_next;
      trig_q_reg   <= qualified;
      trig_d_reg   <= trig_q_reg;
      notfree_reg  <= (need_words > NF_W'(G_FIFO_DEPTH));
    end
  end

  assign Acq_Run     = (state_reg == ACQUIRE);
  assign Busy        = (state_reg != IDLE);
  assign Done        = (state_reg == DONE);
  assign Event_We    = we_reg;
  assign Event_Data  = data_reg;
  assign Trigger_Out = trig_out_reg;
  assign NotFree     = notfree_reg;
  assign Event_Count = count_reg;

endmodule

// File: tb/tb_trigger_event_sequencer.sv
// Directed bench: descriptors are queued when a trigger is driven and
// checked when Event_We fires; pulse counts are checked per scenario.
module tb_trigger_event_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_N;
  logic        Ctrl_Enable, Ctrl_Abort;
  logic [13:0] Ctrl_EventNum;
  logic [31:0] Ctrl_SamplesPerEvent;
  logic [2:0]  Ctrl_TriggerSelect;
  logic [3:0]  Ctrl_Majority;
  logic [7:0]  TRG_ChannelMask, TRG_Detect_Vector;
  logic        EXT_TriggerInput, SW_Trigger;
  logic [14:0] Fifo_WrCount;
  logic        Fifo_AFull;
  logic        Acq_Run, Event_We, Trigger_Out, Busy, NotFree, Done;
  logic [17:0] Event_Data;
  logic [13:0] Event_Count;

  int vectors = 0;
  int miscompares = 0;
  int acq_cnt = 0, trig_cnt = 0, done_cnt = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp_word;

  trigger_event_sequencer dut (
    .Clock(Clock), .Reset_N(Reset_N), .Ctrl_Enable(Ctrl_Enable), .Ctrl_Abort(Ctrl_Abort),
    .Ctrl_EventNum(Ctrl_EventNum), .Ctrl_SamplesPerEvent(Ctrl_SamplesPerEvent),
    .Ctrl_TriggerSelect(Ctrl_TriggerSelect), .Ctrl_Majority(Ctrl_Majority),
    .TRG_ChannelMask(TRG_ChannelMask), .TRG_Detect_Vector(TRG_Detect_Vector),
    .EXT_TriggerInput(EXT_TriggerInput), .SW_Trigger(SW_Trigger),
    .Fifo_WrCount(Fifo_WrCount), .Fifo_AFull(Fifo_AFull), .Acq_Run(Acq_Run),
    .Event_We(Event_We), .Event_Data(Event_Data), .Trigger_Out(Trigger_Out),
    .Busy(Busy), .NotFree(NotFree), .Done(Done), .Event_Count(Event_Count)
  );

  always #5 Clock = ~Clock;

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    acq_cnt = 0;
    trig_cnt = 0;
    done_cnt = 0;
  endtask

  // Descriptor scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge Clock) begin
    if (Reset_N) begin
      if (Acq_Run) acq_cnt++;
      if (Trigger_Out) trig_cnt++;
      if (Done) done_cnt++;
      if (Event_We) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $error("FAIL desc_unexpected: observed 0x%0h expected none", Event_Data);
        end else begin
          exp_word = exp_q.pop_front();
          assert (Event_Data === exp_word) else begin
            miscompares++;
            $error("FAIL desc_word: observed 0x%0h expected 0x%0h", Event_Data, exp_word);
          end
        end
      end
    end
  end

  initial begin
    Reset_N = 1'b0; Ctrl_Enable = 1'b0; Ctrl_Abort = 1'b0; Ctrl_EventNum = '0;
    Ctrl_SamplesPerEvent = '0; Ctrl_TriggerSelect = 3'd0; Ctrl_Majority = '0;
    TRG_ChannelMask = '0; TRG_Detect_Vector = '0; EXT_TriggerInput = 1'b0;
    SW_Trigger = 1'b0; Fifo_WrCount = '0; Fifo_AFull = 1'b0;
    tick(3);
    check("rst_busy", Busy, 0);
    check("rst_acq", Acq_Run, 0);
    check("rst_count", Event_Count, 0);
    check("rst_data", Event_Data, 0);
    check("rst_notfree", NotFree, 0);
    check("rst_done", Done, 0);
    Reset_N = 1'b1;
    tick(2);

    // External trigger, SPE=4, two events then Done
    Ctrl_TriggerSelect = 3'd0; Ctrl_SamplesPerEvent = 4; Ctrl_EventNum = 2;
    Ctrl_Enable = 1'b1;
    tick(2);
    check("a_busy", Busy, 1);
    clear_counts();
    exp_q.push_back(18'h10000);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(1);
    check("a_trig_out", Trigger_Out, 1);
    check("a_we", Event_We, 1);
    tick(9);
    check("a_acq1", acq_cnt, 4);
    exp_q.push_back(18'h10001);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(10);
    check("a_acq2", acq_cnt, 8);
    check("a_trig_cnt", trig_cnt, 2);
    check("a_done", done_cnt, 1);
    check("a_count", Event_Count, 2);
    tick(3);
    check("a_no_rearm", Busy, 0);
    Ctrl_Enable = 1'b0; tick(2);

    // Majority, OR and AND qualification
    Ctrl_EventNum = 0; Ctrl_SamplesPerEvent = 1; Ctrl_TriggerSelect = 3'd3;
    Ctrl_Majority = 3; TRG_ChannelMask = 8'h0F; Ctrl_Enable = 1'b1;
    tick(2);
    clear_counts();
    exp_q.push_back(18'h10000);
    TRG_Detect_Vector = 8'h07; tick(3);
    TRG_Detect_Vector = 8'h0F; tick(10);
    check("b_maj_trig", trig_cnt, 1);
    check("b_maj_acq", acq_cnt, 1);
    TRG_Detect_Vector = 8'h00; tick(3);
    Ctrl_TriggerSelect = 3'd1; TRG_Detect_Vector = 8'h10; tick(4);
    check("b_or_masked", trig_cnt, 1);
    exp_q.push_back(18'h10001);
    TRG_Detect_Vector = 8'h01; tick(5);
    TRG_Detect_Vector = 8'h00; tick(3);
    Ctrl_TriggerSelect = 3'd2; TRG_Detect_Vector = 8'h07; tick(4);
    check("b_and_partial", trig_cnt, 2);
    exp_q.push_back(18'h10002);
    TRG_Detect_Vector = 8'h0F; tick(5);
    check("b_and_trig", trig_cnt, 3);
    check("b_count", Event_Count, 3);
    TRG_Detect_Vector = 8'h00; Ctrl_Enable = 1'b0; tick(2);
    check("b_idle", Busy, 0);

    // FIFO space and almost-full gating
    Ctrl_TriggerSelect = 3'd0; Ctrl_SamplesPerEvent = 8; Fifo_WrCount = 16380;
    Ctrl_Enable = 1'b1;
    tick(2);
    check("c_notfree", NotFree, 1);
    clear_counts();
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(6);
    check("c_dropped_nf", trig_cnt, 0);
    Fifo_WrCount = 16376; Fifo_AFull = 1'b1; tick(2);
    check("c_free", NotFree, 0);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(6);
    check("c_dropped_af", trig_cnt, 0);
    Fifo_AFull = 1'b0; tick(2);
    exp_q.push_back(18'h10000);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(12);
    check("c_accept", trig_cnt, 1);
    check("c_acq", acq_cnt, 8);
    Ctrl_Enable = 1'b0; Fifo_WrCount = '0; tick(2);

    // Abort on the third of ten samples
    Ctrl_SamplesPerEvent = 10; Ctrl_Enable = 1'b1;
    tick(2);
    clear_counts();
    exp_q.push_back(18'h10000);
    exp_q.push_back(18'h20000);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(1);
    tick(2);
    check("d_acq_3rd", Acq_Run, 1);
    Ctrl_Abort = 1'b1; tick(1);
    check("d_acq_drop", Acq_Run, 0);
    check("d_idle", Busy, 0);
    check("d_abort_we", Event_We, 1);
    check("d_count", Event_Count, 0);
    Ctrl_Abort = 1'b0; Ctrl_Enable = 1'b0; tick(3);
    check("d_acq_total", acq_cnt, 3);

    // Reset in the middle of an acquisition
    Ctrl_Enable = 1'b1; tick(2);
    exp_q.push_back(18'h10000);
    EXT_TriggerInput = 1'b1; tick(1); EXT_TriggerInput = 1'b0; tick(3);
    check("e_in_acq", Acq_Run, 1);
    Reset_N = 1'b0; tick(1);
    check("e_acq", Acq_Run, 0);
    check("e_busy", Busy, 0);
    check("e_we", Event_We, 0);
    check("e_trig", Trigger_Out, 0);
    check("e_data", Event_Data, 0);
    check("e_count", Event_Count, 0);
    Reset_N = 1'b1; Ctrl_Enable = 1'b0; tick(3);

    // SPE=0 with software triggers, unlimited events
    Ctrl_TriggerSelect = 3'd4; Ctrl_SamplesPerEvent = 0; Ctrl_EventNum = 0;
    Ctrl_Enable = 1'b1;
    tick(2);
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(18'h10000 + 18'(k));
      SW_Trigger = 1'b1; tick(1); SW_Trigger = 1'b0; tick(4);
    end
    check("f_acq", acq_cnt, 3);
    check("f_count", Event_Count, 3);
    check("f_busy", Busy, 1);
    check("f_done", done_cnt, 0);
    Ctrl_Enable = 1'b0; tick(2);
    check("f_idle", Busy, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trigger_event_sequencer.md
TRIGGER_EVENT_SEQUENCER -- requirements
Module: trigger_event_sequencer

Interface
REQ-001 SHALL have parameter G_CHANNELS, default 8, meaning the number of self-trigger detect channels.
REQ-002 SHALL have parameter G_FIFO_DEPTH, default 16384, meaning the sample FIFO depth in words.
REQ-003 SHALL have parameter G_CNT_WIDTH, default 15, meaning the FIFO write-count width.
REQ-004 SHALL have parameters G_SPE_WIDTH (32) and G_EVNUM_WIDTH (14), meaning the samples-per-event and event-number widths.
REQ-005 SHALL have parameter G_DATA_WIDTH, default 18 (minimum 18), meaning the event-descriptor word width.
REQ-006 SHALL have these ports, one per line:
- Clock  in  1  sole clock, rising edge
- Reset_N  in  1  synchronous, active-low reset
- Ctrl_Enable  in  1  arm the acquisition run
- Ctrl_Abort  in  1  abort the run (level)
- Ctrl_EventNum  in  G_EVNUM_WIDTH  events per run; 0 = unlimited
- Ctrl_SamplesPerEvent  in  G_SPE_WIDTH  samples per event; 0 treated as 1
- Ctrl_TriggerSelect  in  3  0 external, 1 OR, 2 AND, 3 majority, 4 software, 5-7 none
- Ctrl_Majority  in  clog2(G_CHANNELS+1)  majority threshold; 0 treated as 1
- TRG_ChannelMask  in  G_CHANNELS  1 = channel participates
- TRG_Detect_Vector  in  G_CHANNELS  per-channel detect levels
- EXT_TriggerInput  in  1  external trigger level
- SW_Trigger  in  1  software trigger level
- Fifo_WrCount  in  G_CNT_WIDTH  sample FIFO occupancy
- Fifo_AFull  in  1  descriptor FIFO almost full
- Acq_Run  out  1  sample FIFO write enable
- Event_We  out  1  descriptor write strobe
- Event_Data  out  G_DATA_WIDTH  descriptor word
- Trigger_Out  out  1  one-cycle accepted-trigger pulse
- Busy  out  1  state not IDLE
- NotFree  out  1  insufficient FIFO space
- Done  out  1  one-cycle run-complete pulse
- Event_Count  out  G_EVNUM_WIDTH  events completed this run

Function
REQ-007 SHALL qualify trigger as: sel0 EXT_TriggerInput; sel1 OR(detect&mask); sel2 (mask!=0) AND all masked detect=1; sel3 popcount(detect&mask) >= max(Ctrl_Majority,1); sel4 SW_Trigger; sel5-7 constant 0.
REQ-008 SHALL register the qualified trigger and accept only its rising edge (0->1 between consecutive registered samples).
REQ-009 SHALL register NotFree = (G_FIFO_DEPTH - Fifo_WrCount) < max(SPE,1), computed at G_CNT_WIDTH+G_SPE_WIDTH+1 bits, with no wrap.
REQ-010 SHALL implement states IDLE, ARMED, ACQUIRE, DONE.
REQ-011 In IDLE with Ctrl_Enable=1 and Ctrl_Abort=0, SHALL clear Event_Count and go to ARMED.
REQ-012 In ARMED, on an accepted edge with NotFree=0 and Fifo_AFull=0, SHALL go to ACQUIRE; an edge arriving while NotFree or Fifo_AFull is high SHALL be dropped, not queued.
REQ-013 On acceptance at cycle T, SHALL pulse Trigger_Out and Event_We at T+1, with Event_Data = {2'b01, zeros, Event_Count[15:0]} (pre-increment, zero-extended).
REQ-014 SHALL hold Acq_Run high for exactly max(SPE,1) cycles starting at T+1.
REQ-015 After the last Acq_Run cycle, SHALL increment Event_Count; if Ctrl_EventNum!=0 and the new count equals Ctrl_EventNum, SHALL go to DONE, otherwise to ARMED.
REQ-016 Event_Count SHALL wrap to 0 at its maximum when Ctrl_EventNum=0.
REQ-017 DONE SHALL pulse Done for one cycle and go to IDLE; a new run SHALL need Ctrl_Enable low for at least one cycle.
REQ-018 Ctrl_Enable falling in ARMED SHALL go to IDLE; in ACQUIRE the current event SHALL complete first.
REQ-019 Ctrl_Abort in any non-IDLE state SHALL go to IDLE next cycle and drop Acq_Run that cycle; if in ACQUIRE, SHALL write one descriptor {2'b10, zeros, Event_Count[15:0]}, with Event_Count not incremented.
REQ-020 Abort SHALL take priority over trigger acceptance and event completion in the same cycle.
REQ-021 Busy SHALL be high in every state except IDLE.

Reset
REQ-022 Reset_N=0 at a rising edge SHALL force IDLE, clear edge-detect history, and drive Acq_Run, Event_We, Trigger_Out, Done, Busy, NotFree low and Event_Count, Event_Data to 0, including mid-ACQUIRE, with no abort word.

Verification
REQ-023 Ext trigger, SPE=4, EventNum=2, two edges: Event_Data 0x10000 then 0x10001, 4-cycle Acq_Run each, Done once, Event_Count=2.
REQ-024 Majority sel3, Majority=3, mask=0x0F, detect=0x07 then 0x0F held: exactly one trigger, none while held.
REQ-025 Depth 16384, WrCount=16380, SPE=8: NotFree=1, edge dropped; WrCount=16376: accepted.
REQ-026 Abort at 3rd of SPE=10 samples: Acq_Run low next cycle, descriptor 0x20000, Event_Count unchanged, IDLE.
REQ-027 Reset_N low mid-ACQUIRE: all outputs 0 next cycle, no descriptor.
REQ-028 SPE=0 with a sel4 SW_Trigger pulse: one Acq_Run cycle; EventNum=0 runs until Ctrl_Enable is deasserted.
